// File: rtl/rgb_byte_serializer_if.sv
// Byte stream link from the pixel serializer to the UART transmitter.
// The master drives data/valid; the slave answers with ready.
interface rgb_byte_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/rgb_byte_serializer.sv
// Buffers strobed RGB pixels in a small FIFO and emits them as R,G,B bytes over a
// valid/ready link, with a SYNC header byte ahead of pixel 0 of every frame.
module rgb_byte_serializer #(
  parameter int         FIFO_AW   = 4,
  parameter int         FRAME_PIX = 307200,
  parameter int         CNT_W     = 19,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic [7:0]            pi_data_R,
  input  logic [7:0]            pi_data_G,
  input  logic [7:0]            pi_data_B,
  input  logic                  pi_flag,
  rgb_byte_serializer_if.master tx,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  ovf
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_G    = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_PIX - 1);
  localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);

  logic [23:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   level_reg;
  logic [CNT_W-1:0]   pix_cnt_reg;
  logic [CNT_W-1:0]   pix_cnt_next;
  logic [2:0]         state_reg;
  logic [2:0]         state_next;
  logic [23:0]        hold_reg;
  logic               ovf_reg;
  logic               valid;
  logic               xfer;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               drop;
  logic [7:0]         data_mux;

  assign fifo_empty   = (level_reg == '0);
  assign fifo_full    = (level_reg == LEVEL_FULL);
  assign valid        = (state_reg != ST_IDLE);
  assign xfer         = valid && tx.tx_ready;
  assign pix_cnt_next = (pix_cnt_reg == CNT_LAST) ? '0 : pix_cnt_reg + 1'b1;

  // A pop always coincides with the edge that enters R, so hold is loaded exactly then.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (pix_cnt_reg == '0) begin
            state_next = ST_SYNC;
          end else begin
            state_next = ST_R;
            pop        = 1'b1;
          end
        end
      end
      ST_SYNC: begin
        if (xfer) begin
          state_next = ST_R;
          pop        = 1'b1;
        end
      end
      ST_R: if (xfer) state_next = ST_G;
      ST_G: if (xfer) state_next = ST_B;
      ST_B: begin
        if (xfer) begin
          if (pix_cnt_next == '0 || fifo_empty) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_R;
            pop        = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A full FIFO still accepts a pixel when the head leaves on the same edge.
  assign push = pi_flag && (!fifo_full || pop);
  assign drop = pi_flag && fifo_full && !pop;

  always_ff @(posedge sclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {pi_data_R, pi_data_G, pi_data_B};
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      pix_cnt_reg <= '0;
      hold_reg    <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        hold_reg   <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (state_reg == ST_B && xfer) pix_cnt_reg <= pix_cnt_next;
      if (drop) ovf_reg <= 1'b1;
    end
  end

  always_comb begin
    data_mux = 8'h00;
    case (state_reg)
      ST_SYNC: data_mux = SYNC_BYTE;
      ST_R:    data_mux = hold_reg[23:16];
      ST_G:    data_mux = hold_reg[15:8];
      ST_B:    data_mux = hold_reg[7:0];
      default: data_mux = 8'h00;
    endcase
  end

  assign tx.tx_data  = data_mux;
  assign tx.tx_valid = valid;
  assign fifo_level  = level_reg;
  assign ovf         = ovf_reg;

endmodule

// File: tb/tb_rgb_byte_serializer.sv
// Checks the RGB byte serializer with a vector table, hand-built corner sequences
// and a randomized run scored against a byte-stream model of the frame rules.
module tb_rgb_byte_serializer;
  localparam int         FIFO_AW   = 2;
  localparam int         DEPTH     = 4;
  localparam int         FRAME_PIX = 4;
  localparam int         CNT_W     = 3;
  localparam logic [7:0] SYNC      = 8'hA5;

  logic               sclk = 1'b0;
  logic               rst;
  logic [7:0]         pr, pg, pb;
  logic               pflag;
  logic [FIFO_AW:0]   level;
  logic               ovf;

  rgb_byte_serializer_if tx_bus ();

  rgb_byte_serializer #(
    .FIFO_AW  (FIFO_AW),
    .FRAME_PIX(FRAME_PIX),
    .CNT_W    (CNT_W),
    .SYNC_BYTE(SYNC)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .pi_data_R (pr),
    .pi_data_G (pg),
    .pi_data_B (pb),
    .pi_flag   (pflag),
    .tx        (tx_bus),
    .fifo_level(level),
    .ovf       (ovf)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected byte stream: {last-byte-of-pixel flag, byte}
  logic [8:0] exp_q[$];
  int         model_pix;
  int         b_done;
  bit         mon_en;
  bit         prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    if (model_pix % FRAME_PIX == 0) exp_q.push_back({1'b0, SYNC});
    exp_q.push_back({1'b0, r});
    exp_q.push_back({1'b0, g});
    exp_q.push_back({1'b1, b});
    model_pix++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pflag = 1'b0;
    tx_bus.tx_ready = 1'b0;
    exp_q.delete();
    model_pix = 0;
    b_done = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    tx_bus.tx_ready = 1'b1;
    while ((exp_q.size() != 0 || tx_bus.tx_valid) && w < 300) begin
      step();
      w++;
    end
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_idle"}, tx_bus.tx_valid, 1'b0);
    tx_bus.tx_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit model);
    pr = r; pg = g; pb = b;
    pflag = 1'b1;
    if (model) model_push(r, g, b);
    step();
    pflag = 1'b0;
  endtask

  // Transfers happen on the next rising edge; sampled mid-cycle.
  always @(negedge sclk) begin
    logic [8:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", tx_bus.tx_valid, 1'b1);
        chk("stall_data", tx_bus.tx_data, prev_data);
      end
      if (mon_en && tx_bus.tx_valid && tx_bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_byte: got %0h expected no byte", tx_bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("stream", tx_bus.tx_data, e[7:0]);
          if (e[8]) b_done++;
        end
      end
      prev_stall = tx_bus.tx_valid && !tx_bus.tx_ready;
      prev_data  = tx_bus.tx_data;
    end
  end

  typedef struct {
    logic [7:0]  r, g, b;
    int          stall_at;
    int          stall_len;
    logic [31:0] exp_bytes;
    int          nexp;
  } vec_t;

  vec_t vt[6];

  initial begin
    int w;
    logic [7:0] eb;
    rst = 1'b1;
    pflag = 1'b0;
    pr = 8'h00; pg = 8'h00; pb = 8'h00;
    tx_bus.tx_ready = 1'b0;
    mon_en = 1'b0;
    prev_stall = 1'b0;
    prev_data = 8'h00;

    vt[0] = '{8'h11, 8'h22, 8'h33, -1, 0,  32'hA5112233, 4};
    vt[1] = '{8'h01, 8'h02, 8'h03,  1, 20, 32'h01020300, 3};
    vt[2] = '{8'hFF, 8'h00, 8'h80,  0, 3,  32'hFF008000, 3};
    vt[3] = '{8'h7E, 8'h81, 8'h5A, -1, 0,  32'h7E815A00, 3};
    vt[4] = '{8'hC3, 8'h3C, 8'hA5,  0, 5,  32'hA5C33CA5, 4};
    vt[5] = '{8'h00, 8'h00, 8'h00,  3, 2,  32'h00000000, 3};

    do_reset();
    chk("rst_valid", tx_bus.tx_valid, 1'b0);
    chk("rst_data", tx_bus.tx_data, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 1'b0);

    // Single-pixel vectors across a frame wrap, with stalls on chosen bytes
    for (int v = 0; v < 6; v++) begin
      send(vt[v].r, vt[v].g, vt[v].b, 1'b0);
      tx_bus.tx_ready = 1'b0;
      for (int i = 0; i < vt[v].nexp; i++) begin
        eb = vt[v].exp_bytes[31-8*i -: 8];
        w = 0;
        while (!tx_bus.tx_valid && w < 10) begin
          step();
          w++;
        end
        if (i == 0) chk("latency", w, 1);
        else        chk("gap", w, 0);
        if (i == vt[v].stall_at) begin
          repeat (vt[v].stall_len) step();
          chk("stall_end_data", tx_bus.tx_data, eb);
        end
        chk("byte", tx_bus.tx_data, eb);
        tx_bus.tx_ready = 1'b1;
        step();
        tx_bus.tx_ready = 1'b0;
      end
      chk("idle_after", tx_bus.tx_valid, 1'b0);
      chk("level_after", level, 0);
      chk("ovf_after", ovf, 1'b0);
      $display("vector %0d: pixel %02h%02h%02h done", v, vt[v].r, vt[v].g, vt[v].b);
    end

    mon_en = 1'b1;

    // Full FIFO with a push on the same edge as the pop out of SYNC
    do_reset();
    for (int k = 0; k < 4; k++) send(8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k), 1'b1);
    chk("full_level", level, 4);
    chk("full_ovf", ovf, 1'b0);
    pr = 8'h14; pg = 8'h24; pb = 8'h34;
    pflag = 1'b1;
    model_push(pr, pg, pb);
    tx_bus.tx_ready = 1'b1;
    step();
    pflag = 1'b0;
    tx_bus.tx_ready = 1'b0;
    chk("pushpop_level", level, 4);
    chk("pushpop_ovf", ovf, 1'b0);
    chk("pushpop_head", tx_bus.tx_data, 8'h10);
    drain("pushpop");
    $display("sequence push_pop_full: done");

    // Overflow: one pixel in hold plus a full FIFO, sixth strobe dropped
    do_reset();
    send(8'h01, 8'h02, 8'h03, 1'b1);
    drain("ovf_pre");
    for (int k = 0; k < 6; k++) send(8'h40 + 8'(k), 8'h50 + 8'(k), 8'h60 + 8'(k), k < 5);
    chk("ovf_level", level, 4);
    chk("ovf_flag", ovf, 1'b1);
    drain("ovf");
    chk("ovf_sticky", ovf, 1'b1);
    $display("sequence overflow: done");

    // Reset while mid-pixel with pixels queued
    do_reset();
    for (int k = 0; k < 4; k++) send(8'h70 + 8'(k), 8'h80 + 8'(k), 8'h90 + 8'(k), 1'b1);
    tx_bus.tx_ready = 1'b1;
    step();
    step();
    tx_bus.tx_ready = 1'b0;
    chk("midg_data", tx_bus.tx_data, 8'h80);
    chk("midg_level", level, 3);
    rst = 1'b1;
    exp_q.delete();
    model_pix = 0;
    b_done = 0;
    step();
    rst = 1'b0;
    chk("midrst_valid", tx_bus.tx_valid, 1'b0);
    chk("midrst_level", level, 0);
    chk("midrst_data", tx_bus.tx_data, 8'h00);
    send(8'hDE, 8'hAD, 8'hBE, 1'b1);
    drain("midrst");
    $display("sequence reset_mid_pixel: done");

    // Randomized traffic with random backpressure, kept below overflow
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tx_bus.tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && (model_pix - b_done) < DEPTH) begin
        pr = 8'($urandom);
        pg = 8'($urandom);
        pb = 8'($urandom);
        pflag = 1'b1;
        model_push(pr, pg, pb);
      end else begin
        pflag = 1'b0;
      end
      step();
    end
    pflag = 1'b0;
    drain("rand");
    chk("rand_level", level, 0);
    chk("rand_ovf", ovf, 1'b0);
    $display("random run: %0d pixels sent", model_pix);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
